// File: rtl/sram_port_sequencer_pkg.sv
// Shared types and defaults for the register-file SRAM port sequencer.
`ifndef SIZE_RMT
`define SIZE_RMT 32
`endif

package sram_port_sequencer_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    localparam int SRAM_DEPTH_DEF = 64;
    localparam int SRAM_INDEX_DEF = 6;
    localparam int SRAM_WIDTH_DEF = 8;
    localparam int NUM_RD_DEF     = 10;
    localparam int NUM_WR_DEF     = 5;
    localparam int INIT_START_DEF = `SIZE_RMT;

    // Flattened width of a per-port bus.
    function automatic int bus_w(input int ports, input int slice_w);
        return ports * slice_w;
    endfunction

endpackage

// File: rtl/sram_port_sequencer_if.sv
// Request, SRAM-facing and response signals of the port sequencer.
interface sram_port_sequencer_if
    import sram_port_sequencer_pkg::*;
#(
    parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
    parameter int SRAM_INDEX = SRAM_INDEX_DEF,
    parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF
);
    logic [NUM_RD-1:0][SRAM_INDEX-1:0] rd_addr_i;
    logic [NUM_RD-1:0]                 rd_valid_i;
    logic [NUM_WR-1:0][SRAM_INDEX-1:0] wr_addr_i;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0] wr_data_i;
    logic [NUM_WR-1:0]                 wr_valid_i;
    logic                              ready_o;
    logic [NUM_RD-1:0][SRAM_DEPTH-1:0] decoded_rd_o;
    logic [NUM_WR-1:0][SRAM_DEPTH-1:0] decoded_wr_o;
    logic [NUM_WR-1:0]                 we_o;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0] data_wr_o;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0] sram_rd_data_i;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0] rd_data_o;
    logic                              wr_conflict_o;

    modport slave (
        input  rd_addr_i, rd_valid_i, wr_addr_i, wr_data_i, wr_valid_i, sram_rd_data_i,
        output ready_o, decoded_rd_o, decoded_wr_o, we_o, data_wr_o, rd_data_o, wr_conflict_o
    );

    modport master (
        output rd_addr_i, rd_valid_i, wr_addr_i, wr_data_i, wr_valid_i, sram_rd_data_i,
        input  ready_o, decoded_rd_o, decoded_wr_o, we_o, data_wr_o, rd_data_o, wr_conflict_o
    );

endinterface

// File: rtl/sram_port_sequencer_onehot_decoder.sv
// Binary-to-one-hot address decoder with a valid gate; out-of-range addresses decode to zero.
module onehot_decoder #(
    parameter int IDX_W = 6,
    parameter int DEPTH = 64
) (
    input  logic             valid,
    input  logic [IDX_W-1:0] addr,
    output logic [DEPTH-1:0] onehot
);
    for (genvar a = 0; a < DEPTH; a++) begin : g_bit
        assign onehot[a] = valid && (addr == IDX_W'(a));
    end
endmodule

// File: rtl/sram_port_sequencer.sv
// Requester front end for multi-ported decoded-address RF SRAMs: init sweep, one-stage
// request register, one-hot decode and write-to-read bypass.
module sram_port_sequencer
    import sram_port_sequencer_pkg::*;
#(
    parameter int SRAM_DEPTH = SRAM_DEPTH_DEF,
    parameter int SRAM_INDEX = SRAM_INDEX_DEF,
    parameter int SRAM_WIDTH = SRAM_WIDTH_DEF,
    parameter int NUM_RD     = NUM_RD_DEF,
    parameter int NUM_WR     = NUM_WR_DEF,
    parameter int INIT_START = INIT_START_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    sram_port_sequencer_if.slave    bus
);
    localparam bit                    SKIP_INIT = (INIT_START >= SRAM_DEPTH);
    localparam logic [SRAM_INDEX-1:0] CNT_START = SRAM_INDEX'(INIT_START);
    localparam logic [SRAM_INDEX-1:0] CNT_LAST  = SRAM_INDEX'(SRAM_DEPTH - 1);

    seq_state_e                        state_q, state_d;
    logic [SRAM_INDEX-1:0]             cnt_q, cnt_d;
    logic                              ready_q;
    logic [NUM_RD-1:0][SRAM_INDEX-1:0] rd_addr_q;
    logic [NUM_RD-1:0]                 rd_vld_q;
    logic [NUM_WR-1:0][SRAM_INDEX-1:0] wr_addr_q;
    logic [NUM_WR-1:0][SRAM_WIDTH-1:0] wr_data_q;
    logic [NUM_WR-1:0]                 wr_vld_q;
    logic                              conflict_d, conflict_q;
    logic [NUM_RD-1:0][SRAM_WIDTH-1:0] rd_data;

    // The counter holds on the last entry rather than wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (SKIP_INIT || cnt_q == CNT_LAST) state_d = ST_RUN;
            else                                 cnt_d   = cnt_q + 1'b1;
        end
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_WR; i++)
            for (int j = i + 1; j < NUM_WR; j++)
                if (bus.wr_valid_i[i] && bus.wr_valid_i[j] && bus.wr_addr_i[i] == bus.wr_addr_i[j])
                    conflict_d = 1'b1;
    end

    // ready lags RUN by a cycle so the last sweep write is on the bus before traffic is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= CNT_START;
            ready_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_vld_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_vld_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_q == ST_RUN);
            if (ready_q) begin
                rd_addr_q  <= bus.rd_addr_i;
                rd_vld_q   <= bus.rd_valid_i;
                wr_addr_q  <= bus.wr_addr_i;
                wr_vld_q   <= bus.wr_valid_i;
                conflict_q <= conflict_d;
                for (int w = 0; w < NUM_WR; w++)
                    wr_data_q[w] <= bus.wr_valid_i[w] ? bus.wr_data_i[w] : '0;
            end else begin
                rd_addr_q  <= '0;
                rd_vld_q   <= '0;
                wr_addr_q  <= '0;
                wr_data_q  <= '0;
                wr_vld_q   <= '0;
                conflict_q <= 1'b0;
                if (state_q == ST_INIT && !SKIP_INIT) begin
                    wr_vld_q[0]  <= 1'b1;
                    wr_addr_q[0] <= cnt_q;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_dec
        onehot_decoder #(.IDX_W(SRAM_INDEX), .DEPTH(SRAM_DEPTH)) u_dec (
            .valid  (rd_vld_q[p]),
            .addr   (rd_addr_q[p]),
            .onehot (bus.decoded_rd_o[p])
        );
    end

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_dec
        onehot_decoder #(.IDX_W(SRAM_INDEX), .DEPTH(SRAM_DEPTH)) u_dec (
            .valid  (wr_vld_q[w]),
            .addr   (wr_addr_q[w]),
            .onehot (bus.decoded_wr_o[w])
        );
    end

    // Ascending scan: the highest-index matching write overrides, like the SRAM's write priority.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (rd_vld_q[p]) rd_data[p] = bus.sram_rd_data_i[p];
            for (int w = 0; w < NUM_WR; w++)
                if (rd_vld_q[p] && wr_vld_q[w] && wr_addr_q[w] == rd_addr_q[p] &&
                    int'(rd_addr_q[p]) < SRAM_DEPTH)
                    rd_data[p] = wr_data_q[w];
        end
    end

    assign bus.rd_data_o     = rd_data;
    assign bus.we_o          = wr_vld_q;
    assign bus.data_wr_o     = wr_data_q;
    assign bus.ready_o       = ready_q;
    assign bus.wr_conflict_o = conflict_q;

endmodule

// File: tb/tb_sram_port_sequencer.sv
// Directed bench for sram_port_sequencer: init sweep, decode, bypass, conflict and reset.
module tb_sram_port_sequencer;
    localparam int DEPTH  = 64;
    localparam int IDX    = 6;
    localparam int W      = 8;
    localparam int NRD    = 10;
    localparam int NWR    = 5;
    localparam int ISTART = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    sram_port_sequencer_if #(
        .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(W), .NUM_RD(NRD), .NUM_WR(NWR)
    ) bus ();

    sram_port_sequencer #(
        .SRAM_DEPTH(DEPTH), .SRAM_INDEX(IDX), .SRAM_WIDTH(W),
        .NUM_RD(NRD), .NUM_WR(NWR), .INIT_START(ISTART)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int a);
        logic [63:0] v;
        v = 64'd1 << a;
        return v;
    endfunction

    task automatic idle();
        bus.rd_valid_i = '0;
        bus.rd_addr_i  = '0;
        bus.wr_valid_i = '0;
        bus.wr_addr_i  = '0;
        bus.wr_data_i  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready_o), 64'd0);
        chk({tag, "_we"}, 64'(bus.we_o), 64'd0);
        chk({tag, "_dwr"}, 64'($countones(bus.decoded_wr_o)), 64'd0);
        chk({tag, "_drd"}, 64'($countones(bus.decoded_rd_o)), 64'd0);
        chk({tag, "_data"}, 64'($countones(bus.data_wr_o)), 64'd0);
        chk({tag, "_conf"}, 64'(bus.wr_conflict_o), 64'd0);
        chk({tag, "_rdata"}, 64'($countones(bus.rd_data_o)), 64'd0);
    endtask

    initial begin
        idle();
        for (int p = 0; p < NRD; p++) bus.sram_rd_data_i[p] = 8'h5A;
        bus.sram_rd_data_i[3] = 8'hA5;

        #12;
        chk_quiet("rst");

        // Requests held during the whole sweep must be ignored.
        @(negedge clk);
        reset = 1'b1;
        bus.rd_valid_i = '1;
        for (int p = 0; p < NRD; p++) bus.rd_addr_i[p] = 6'd4;
        bus.wr_valid_i = '1;
        for (int w = 0; w < NWR; w++) begin
            bus.wr_addr_i[w] = IDX'(w + 1);
            bus.wr_data_i[w] = 8'hFF;
        end

        for (int k = 1; k <= DEPTH - ISTART; k++) begin
            step();
            chk($sformatf("sweep%0d_we", k), 64'(bus.we_o), 64'h1);
            chk($sformatf("sweep%0d_dwr0", k), bus.decoded_wr_o[0], oh(ISTART - 1 + k));
            chk($sformatf("sweep%0d_dwr_n", k), 64'($countones(bus.decoded_wr_o)), 64'd1);
            chk($sformatf("sweep%0d_data", k), 64'($countones(bus.data_wr_o)), 64'd0);
            chk($sformatf("sweep%0d_ready", k), 64'(bus.ready_o), 64'd0);
            chk($sformatf("sweep%0d_drd", k), 64'($countones(bus.decoded_rd_o)), 64'd0);
            chk($sformatf("sweep%0d_conf", k), 64'(bus.wr_conflict_o), 64'd0);
        end
        idle();

        step();
        chk("post_ready", 64'(bus.ready_o), 64'd1);
        chk("post_we", 64'(bus.we_o), 64'd0);
        chk("post_dwr", 64'($countones(bus.decoded_wr_o)), 64'd0);
        chk("post_drd", 64'($countones(bus.decoded_rd_o)), 64'd0);
        chk("post_conf", 64'(bus.wr_conflict_o), 64'd0);

        // Plain read, duplicate-address writes with bypass, and an invalid read.
        bus.rd_valid_i[3] = 1'b1; bus.rd_addr_i[3] = 6'd5;
        bus.rd_valid_i[0] = 1'b1; bus.rd_addr_i[0] = 6'd7;
        bus.rd_valid_i[2] = 1'b0; bus.rd_addr_i[2] = 6'd9;
        bus.wr_valid_i[1] = 1'b1; bus.wr_addr_i[1] = 6'd7; bus.wr_data_i[1] = 8'h11;
        bus.wr_valid_i[4] = 1'b1; bus.wr_addr_i[4] = 6'd7; bus.wr_data_i[4] = 8'h44;
        step();
        idle();
        chk("t2_drd3", bus.decoded_rd_o[3], 64'h20);
        chk("t2_rdata3", 64'(bus.rd_data_o[3]), 64'hA5);
        chk("t3_drd0", bus.decoded_rd_o[0], oh(7));
        chk("t3_rdata0", 64'(bus.rd_data_o[0]), 64'h44);
        chk("t3_conf", 64'(bus.wr_conflict_o), 64'd1);
        chk("t3_we", 64'(bus.we_o), 64'b10010);
        chk("t3_dwr1", bus.decoded_wr_o[1], oh(7));
        chk("t3_dwr4", bus.decoded_wr_o[4], oh(7));
        chk("t3_dwr0", bus.decoded_wr_o[0], 64'd0);
        chk("t3_data1", 64'(bus.data_wr_o[1]), 64'h11);
        chk("t3_data4", 64'(bus.data_wr_o[4]), 64'h44);
        chk("t3_data0", 64'(bus.data_wr_o[0]), 64'h00);
        chk("t4_drd2", bus.decoded_rd_o[2], 64'd0);
        chk("t4_rdata2", 64'(bus.rd_data_o[2]), 64'd0);
        chk("t4_rdata1", 64'(bus.rd_data_o[1]), 64'd0);

        step();
        chk("idle_we", 64'(bus.we_o), 64'd0);
        chk("idle_conf", 64'(bus.wr_conflict_o), 64'd0);
        chk("idle_rdata", 64'($countones(bus.rd_data_o)), 64'd0);

        // Distinct write addresses: bypass per address, top entry decode, no conflict.
        bus.wr_valid_i[0] = 1'b1; bus.wr_addr_i[0] = 6'd3;  bus.wr_data_i[0] = 8'h33;
        bus.wr_valid_i[2] = 1'b1; bus.wr_addr_i[2] = 6'd10; bus.wr_data_i[2] = 8'hAA;
        bus.rd_valid_i[5] = 1'b1; bus.rd_addr_i[5] = 6'd10;
        bus.rd_valid_i[6] = 1'b1; bus.rd_addr_i[6] = 6'd3;
        bus.rd_valid_i[7] = 1'b1; bus.rd_addr_i[7] = 6'd63;
        step();
        idle();
        chk("d_rdata5", 64'(bus.rd_data_o[5]), 64'hAA);
        chk("d_rdata6", 64'(bus.rd_data_o[6]), 64'h33);
        chk("d_rdata7", 64'(bus.rd_data_o[7]), 64'h5A);
        chk("d_drd7", bus.decoded_rd_o[7], oh(63));
        chk("d_conf", 64'(bus.wr_conflict_o), 64'd0);
        chk("d_we", 64'(bus.we_o), 64'b00101);

        // Duplicate writes presented with the higher port holding the winning data.
        bus.wr_valid_i[3] = 1'b1; bus.wr_addr_i[3] = 6'd20; bus.wr_data_i[3] = 8'h30;
        bus.wr_valid_i[0] = 1'b1; bus.wr_addr_i[0] = 6'd20; bus.wr_data_i[0] = 8'h01;
        bus.rd_valid_i[9] = 1'b1; bus.rd_addr_i[9] = 6'd20;
        bus.rd_valid_i[1] = 1'b1; bus.rd_addr_i[1] = 6'd21;
        step();
        chk("p_rdata9", 64'(bus.rd_data_o[9]), 64'h30);
        chk("p_rdata1", 64'(bus.rd_data_o[1]), 64'h5A);
        chk("p_conf", 64'(bus.wr_conflict_o), 64'd1);
        chk("p_we", 64'(bus.we_o), 64'b01001);

        // Reset with traffic still presented: everything drops asynchronously.
        #2 reset = 1'b0;
        #1 chk_quiet("mid_traffic_rst");
        idle();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk($sformatf("sw2_%0d_dwr0", k), bus.decoded_wr_o[0], oh(ISTART - 1 + k));
        end
        #2 reset = 1'b0;
        #1 chk_quiet("mid_sweep_rst");
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("restart_we", 64'(bus.we_o), 64'h1);
        chk("restart_dwr0", bus.decoded_wr_o[0], oh(ISTART));
        step();
        chk("restart2_dwr0", bus.decoded_wr_o[0], oh(ISTART + 1));
        chk("restart2_ready", 64'(bus.ready_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
